// File: rtl/day_set_ctrl.sv
// ---------------------------------------------------------------------------
// day_set_ctrl
//
// Holds the day-of-week index (0=Mon .. 6=Sun) for the display path.
// In RUN the day advances on the midnight tick. In SET the user adjusts the
// day with up/down buttons while the display blinks. SET mode is left with
// another set press, or on its own after TIMEOUT idle cycles.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous reset, active-high
//   day_tick   one-cycle pulse at midnight
//   set_btn    debounced level; each rising edge toggles SET mode
//   up_btn     debounced level; each rising edge increments day in SET
//   down_btn   debounced level; each rising edge decrements day in SET
//   day        current day index 0..6 for the segment decoder
//   setting    1 while in SET mode
//   blank      1 = display off during the blink phase (always 0 in RUN)
//   week_wrap  one-cycle pulse when the midnight tick takes Sun to Mon
// ---------------------------------------------------------------------------
module day_set_ctrl #(
   parameter int BLINK_DIV = 25000000,
   parameter int TIMEOUT   = 250000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       day_tick,
   input  logic       set_btn,
   input  logic       up_btn,
   input  logic       down_btn,
   output logic [2:0] day,
   output logic       setting,
   output logic       blank,
   output logic       week_wrap
);

   // Widths sized from N+1 so a divisor of 1 still gets a 1-bit counter.
   localparam int BLINK_W = $clog2(BLINK_DIV + 1);
   localparam int TMO_W   = $clog2(TIMEOUT + 1);

   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
   localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0]   TMO_ONE    = TMO_W'(1);

   typedef enum logic [0:0] {
      ST_RUN = 1'b0,
      ST_SET = 1'b1
   } state_t;

   state_t               state_reg,     state_next;
   logic [2:0]           day_reg,       day_next;
   logic                 blank_reg,     blank_next;
   logic                 week_wrap_reg, week_wrap_next;
   logic [BLINK_W-1:0]   blink_reg,     blink_next;
   logic [TMO_W-1:0]     tmo_reg,       tmo_next;

   // Previous button levels for rising-edge detection.
   logic set_prev_reg, up_prev_reg, down_prev_reg;

   logic set_edge, up_edge, down_edge;
   logic [2:0] day_inc, day_dec;

   assign set_edge  = set_btn  & ~set_prev_reg;
   assign up_edge   = up_btn   & ~up_prev_reg;
   assign down_edge = down_btn & ~down_prev_reg;

   // Modulo-7 neighbours of the current day; 7 is never produced.
   assign day_inc = (day_reg == 3'd6) ? 3'd0 : day_reg + 3'd1;
   assign day_dec = (day_reg == 3'd0) ? 3'd6 : day_reg - 3'd1;

   // -----------------------------------------------------------------------
   // State register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_RUN;
         day_reg       <= 3'd0;
         blank_reg     <= 1'b0;
         week_wrap_reg <= 1'b0;
         blink_reg     <= '0;
         tmo_reg       <= '0;
         // Seeded high so a button held through reset gives no edge.
         set_prev_reg  <= 1'b1;
         up_prev_reg   <= 1'b1;
         down_prev_reg <= 1'b1;
      end else begin
         state_reg     <= state_next;
         day_reg       <= day_next;
         blank_reg     <= blank_next;
         week_wrap_reg <= week_wrap_next;
         blink_reg     <= blink_next;
         tmo_reg       <= tmo_next;
         set_prev_reg  <= set_btn;
         up_prev_reg   <= up_btn;
         down_prev_reg <= down_btn;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      day_next       = day_reg;
      blank_next     = blank_reg;
      week_wrap_next = 1'b0;
      blink_next     = blink_reg;
      tmo_next       = tmo_reg;

      case (state_reg)
         ST_RUN: begin
            blank_next = 1'b0;
            blink_next = '0;
            tmo_next   = '0;
            // Tick is applied even when a set edge arrives in the same
            // cycle; the mode change happens on top of it.
            if (day_tick) begin
               day_next       = day_inc;
               week_wrap_next = (day_reg == 3'd6);
            end
            if (set_edge) begin
               state_next = ST_SET;
            end
         end

         ST_SET: begin
            // Simultaneous up and down cancel. Midnight ticks are dropped.
            if (up_edge && !down_edge) begin
               day_next = day_inc;
            end else if (down_edge && !up_edge) begin
               day_next = day_dec;
            end

            if (blink_reg == BLINK_LAST) begin
               blink_next = '0;
               blank_next = ~blank_reg;
            end else begin
               blink_next = blink_reg + BLINK_ONE;
            end

            if (set_edge) begin
               state_next = ST_RUN;
               blank_next = 1'b0;
               blink_next = '0;
               tmo_next   = '0;
            end else if (up_edge || down_edge) begin
               tmo_next = '0;
            end else if (tmo_reg == TMO_LAST) begin
               state_next = ST_RUN;
               blank_next = 1'b0;
               blink_next = '0;
               tmo_next   = '0;
            end else begin
               tmo_next = tmo_reg + TMO_ONE;
            end
         end

         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   assign day       = day_reg;
   assign setting   = (state_reg == ST_SET);
   assign blank     = blank_reg;
   assign week_wrap = week_wrap_reg;

endmodule

// File: tb/tb_day_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_day_set_ctrl
//
// Directed vector table, a hand-written timeout sequence and a randomized
// run, all checked against an arithmetic reference model of the day/mode
// behaviour (BLINK_DIV=4, TIMEOUT=50).
// ---------------------------------------------------------------------------
module tb_day_set_ctrl;

   localparam int BLINK_DIV = 4;
   localparam int TIMEOUT   = 50;

   logic       clk = 1'b0;
   logic       rst, day_tick, set_btn, up_btn, down_btn;
   logic [2:0] day;
   logic       setting, blank, week_wrap;

   int n_assert = 0;
   int n_fail   = 0;

   day_set_ctrl #(
      .BLINK_DIV (BLINK_DIV),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .day_tick  (day_tick),
      .set_btn   (set_btn),
      .up_btn    (up_btn),
      .down_btn  (down_btn),
      .day       (day),
      .setting   (setting),
      .blank     (blank),
      .week_wrap (week_wrap)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int m_day;
   bit m_set;
   int m_set_cycles;   // clock edges spent in SET since entry
   int m_idle;         // clock edges in SET since entry or last button edge
   bit m_wrap;
   bit p_s, p_u, p_d;

   function automatic int m_blank();
      return m_set ? ((m_set_cycles / BLINK_DIV) % 2) : 0;
   endfunction

   task automatic model_update(input bit [4:0] in);
      bit r, t, s, u, d, es, eu, ed;
      {r, t, s, u, d} = in;
      if (r) begin
         m_day = 0; m_set = 0; m_set_cycles = 0; m_idle = 0; m_wrap = 0;
         p_s = 1; p_u = 1; p_d = 1;
         return;
      end
      es = s && !p_s;
      eu = u && !p_u;
      ed = d && !p_d;
      p_s = s; p_u = u; p_d = d;
      m_wrap = 0;
      if (!m_set) begin
         if (t) begin
            m_wrap = (m_day == 6);
            m_day  = (m_day + 1) % 7;
         end
         if (es) begin
            m_set = 1; m_set_cycles = 0; m_idle = 0;
         end
      end else begin
         if (eu && !ed)      m_day = (m_day + 1) % 7;
         else if (ed && !eu) m_day = (m_day + 6) % 7;
         m_set_cycles++;
         if (es) begin
            m_set = 0;
         end else if (eu || ed) begin
            m_idle = 0;
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT) m_set = 0;
         end
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs {rst,tick,set,up,down}, then compare to model.
   task automatic step(input bit [4:0] in);
      {rst, day_tick, set_btn, up_btn, down_btn} = in;
      @(posedge clk);
      model_update(in);
      #1;
      check("model_day",       int'(day),       m_day);
      check("model_setting",   int'(setting),   int'(m_set));
      check("model_blank",     int'(blank),     m_blank());
      check("model_week_wrap", int'(week_wrap), int'(m_wrap));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      bit [4:0] in;      // {rst, tick, set, up, down}
      bit [2:0] eday;
      bit [2:0] eflags;  // {setting, blank, week_wrap}
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit [4:0] in, input bit [2:0] eday, input bit [2:0] ef);
      vec_t v;
      v.in = in; v.eday = eday; v.eflags = ef;
      vecs.push_back(v);
   endtask

   initial begin
      bit [4:0] rin;
      bit ls, lu, ld;
      int act;

      rst = 1; day_tick = 0; set_btn = 0; up_btn = 0; down_btn = 0;

      //   {r,t,s,u,d}  day   {set,blank,wrap}
      add(5'b10100, 3'd0, 3'b000); // reset with set held
      add(5'b00100, 3'd0, 3'b000); // held set after reset: no edge
      add(5'b00000, 3'd0, 3'b000);
      add(5'b01000, 3'd1, 3'b000); // tick
      add(5'b01100, 3'd2, 3'b100); // tick + set edge: tick first, enter SET
      add(5'b00110, 3'd3, 3'b100); // up
      add(5'b00100, 3'd3, 3'b100);
      add(5'b00111, 3'd3, 3'b100); // up+down cancel
      add(5'b00100, 3'd3, 3'b110); // blank after 4 cycles
      add(5'b00101, 3'd2, 3'b110); // down
      add(5'b01100, 3'd2, 3'b110); // tick ignored in SET
      add(5'b00000, 3'd2, 3'b110);
      add(5'b00110, 3'd3, 3'b000); // set edge + up: up applied, back to RUN
      add(5'b01110, 3'd4, 3'b000); // RUN tick, held buttons give no edge
      add(5'b01000, 3'd5, 3'b000);
      add(5'b01000, 3'd6, 3'b000);
      add(5'b01000, 3'd0, 3'b001); // Sun -> Mon wraps
      add(5'b00000, 3'd0, 3'b000); // wrap lasts one cycle
      add(5'b00100, 3'd0, 3'b100); // enter SET
      add(5'b00100, 3'd0, 3'b100);
      add(5'b00100, 3'd0, 3'b100);
      add(5'b00100, 3'd0, 3'b100);
      add(5'b00100, 3'd0, 3'b110); // blank=1
      add(5'b10100, 3'd0, 3'b000); // reset mid-SET
      add(5'b00100, 3'd0, 3'b000);
      add(5'b00000, 3'd0, 3'b000);
      add(5'b00100, 3'd0, 3'b100); // enter SET at Mon
      add(5'b00101, 3'd6, 3'b100); // down wraps 0 -> 6
      add(5'b00100, 3'd6, 3'b100);

      foreach (vecs[i]) begin
         step(vecs[i].in);
         check($sformatf("vec%0d_day", i),     int'(day),       int'(vecs[i].eday));
         check($sformatf("vec%0d_setting", i), int'(setting),   int'(vecs[i].eflags[2]));
         check($sformatf("vec%0d_blank", i),   int'(blank),     int'(vecs[i].eflags[1]));
         check($sformatf("vec%0d_wrap", i),    int'(week_wrap), int'(vecs[i].eflags[0]));
      end
      $display("directed vectors applied: %0d", vecs.size());

      // Timeout: one idle cycle already passed; 48 more keep SET active,
      // the 50th idle cycle returns to RUN.
      for (int i = 0; i < 48; i++) begin
         step(5'b00100);
         check("timeout_still_set", int'(setting), 1);
      end
      step(5'b00100);
      check("timeout_setting", int'(setting), 0);
      check("timeout_blank",   int'(blank),   0);
      step(5'b01100);
      check("post_timeout_tick_day",  int'(day),       0);
      check("post_timeout_tick_wrap", int'(week_wrap), 1);
      $display("timeout sequence done: day=%0d setting=%0d", day, setting);

      // Randomized run in segments of varying button activity.
      ls = 1; lu = 0; ld = 0;
      for (int seg = 0; seg < 20; seg++) begin
         act = $urandom_range(1, 6);
         for (int c = 0; c < 150; c++) begin
            if ($urandom_range(0, act * 8) == 0) ls = ~ls;
            if ($urandom_range(0, act * 3) == 0) lu = ~lu;
            if ($urandom_range(0, act * 3) == 0) ld = ~ld;
            rin = {($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0), ls, lu, ld};
            step(rin);
         end
         $display("random segment %0d: activity=%0d day=%0d setting=%0d", seg, act, day, setting);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
